// File: rtl/writeback_regfile_pkg.sv
// Shared Y86-64 definitions: icodes, register ids and status codes.
package y86_defs;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

endpackage

// File: rtl/writeback_regfile_if.sv
// Write-back bundle and decode read ports of the register file.
interface writeback_regfile_if;

    logic        wb_valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        mem_error;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;

    modport master (
        output wb_valid, icode, cnd, rA, rB, valE, valM, mem_error, srcA, srcB,
        input  valA, valB
    );

    modport slave (
        input  wb_valid, icode, cnd, rA, rB, valE, valM, mem_error, srcA, srcB,
        output valA, valB
    );

endinterface

// File: rtl/writeback_regfile_dst_sel.sv
// Destination register selection from the retiring instruction fields.
module wb_dst_sel
    import y86_defs::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m
);

    // dstE/dstM decode; unused destinations are RNONE
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            IRRMOVQ:                    dst_e = cnd ? rb : RNONE;
            IIRMOVQ, IOPQ:              dst_e = rb;
            ICALL, IRET, IPUSHQ, IPOPQ: dst_e = RRSP;
            default:                    dst_e = RNONE;
        endcase
        if (icode == IMRMOVQ || icode == IPOPQ) begin
            dst_m = ra;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: register file, status FSM and retire counter.
module writeback_regfile
    import y86_defs::*;
#(
    parameter bit          REG_INIT_IDX = 1'b1,
    parameter bit          BYPASS       = 1'b1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    writeback_regfile_if.slave wb,
    output logic [2:0]       stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    logic [63:0]      regs_q [15];
    stat_e            stat_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  dst_e, dst_m;
    logic        accept, fault_adr, fault_ins, commit, we_e, we_m;
    logic [63:0] stored_a, stored_b;

    wb_dst_sel u_dst_sel (
        .icode (wb.icode),
        .cnd   (wb.cnd),
        .ra    (wb.rA),
        .rb    (wb.rB),
        .dst_e (dst_e),
        .dst_m (dst_m)
    );

    // Gating with rst_n_i keeps the bypass from showing a write that reset will discard
    always_comb begin
        accept    = wb.wb_valid && (stat_q == STAT_AOK) && rst_n_i;
        fault_adr = wb.mem_error;
        fault_ins = (wb.icode >= 4'hC);
        commit    = accept && !fault_adr && !fault_ins;
        we_e      = commit && (dst_e != RNONE);
        we_m      = commit && (dst_m != RNONE);
    end

    // Register array; valM has priority when both ports target the same register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= REG_INIT_IDX ? 64'(i) : 64'd0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (we_m && dst_m == 4'(i)) begin
                    regs_q[i] <= wb.valM;
                end else if (we_e && dst_e == 4'(i)) begin
                    regs_q[i] <= wb.valE;
                end
            end
        end
    end

    // Status FSM: ADR > INS > HLT, all terminal until reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_q <= STAT_AOK;
        end else if (accept) begin
            if (fault_adr) begin
                stat_q <= STAT_ADR;
            end else if (fault_ins) begin
                stat_q <= STAT_INS;
            end else if (wb.icode == IHALT) begin
                stat_q <= STAT_HLT;
            end
        end
    end

    // Retired-instruction counter; halt counts, faulting instructions do not
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (commit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Stored-value lookup; index F falls through to zero
    always_comb begin
        stored_a = 64'd0;
        stored_b = 64'd0;
        for (int i = 0; i < 15; i++) begin
            if (wb.srcA == 4'(i)) stored_a = regs_q[i];
            if (wb.srcB == 4'(i)) stored_b = regs_q[i];
        end
    end

    // Read ports with optional same-cycle forwarding, valM before valE
    always_comb begin
        wb.valA = stored_a;
        wb.valB = stored_b;
        if (BYPASS) begin
            if (we_m && wb.srcA == dst_m)      wb.valA = wb.valM;
            else if (we_e && wb.srcA == dst_e) wb.valA = wb.valE;
            if (we_m && wb.srcB == dst_m)      wb.valB = wb.valM;
            else if (we_e && wb.srcB == dst_e) wb.valB = wb.valE;
        end
    end

    assign stat_o        = stat_q;
    assign halted_o      = (stat_q != STAT_AOK);
    assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile with directed vectors.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] cnt;

    writeback_regfile_if wbif ();

    writeback_regfile #(
        .REG_INIT_IDX (1'b1),
        .BYPASS       (1'b1),
        .CNT_W        (32)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .wb            (wbif.slave),
        .stat_o        (stat),
        .halted_o      (halted),
        .retired_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  st;
        logic        h;
        logic [31:0] c;
    } exp_t;

    exp_t exp_q[$];
    bit   done = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    // Drive one cycle of stimulus just after the rising edge and queue its expectation
    task automatic step(input int id, input bit r, input bit v, input logic [3:0] ic,
                        input bit c, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] ve, input logic [63:0] vm, input bit me,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input logic [63:0] ea, input logic [63:0] eb,
                        input logic [2:0] es, input logic [31:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = r;
        wbif.wb_valid  = v;
        wbif.icode     = ic;
        wbif.cnd       = c;
        wbif.rA        = ra;
        wbif.rB        = rb;
        wbif.valE      = ve;
        wbif.valM      = vm;
        wbif.mem_error = me;
        wbif.srcA      = sa;
        wbif.srcB      = sb;
        e.id = id; e.a = ea; e.b = eb; e.st = es; e.h = (es != 3'd1); e.c = ec;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input int id, input string fld, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", id, fld, act, req);
        end
    endtask

    // Monitor: compare DUT outputs on the falling edge against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.id, "valA", wbif.valA, e.a);
                cmp(e.id, "valB", wbif.valB, e.b);
                cmp(e.id, "stat", 64'(stat), 64'(e.st));
                cmp(e.id, "halted", 64'(halted), 64'(e.h));
                cmp(e.id, "cnt", 64'(cnt), 64'(e.c));
            end else if (done) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b1;
        wbif.wb_valid  = 1'b0;
        wbif.icode     = 4'h1;
        wbif.cnd       = 1'b0;
        wbif.rA        = 4'hF;
        wbif.rB        = 4'hF;
        wbif.valE      = 64'd0;
        wbif.valM      = 64'd0;
        wbif.mem_error = 1'b0;
        wbif.srcA      = 4'hF;
        wbif.srcB      = 4'hF;
        #2 rst_n = 1'b0;

        //   id rst v  ic   c  rA    rB    valE          valM          me srcA  srcB  expA          expB         st cnt
        step(1, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,        64'h0,        0, 4'h3, 4'hF, 64'h3,        64'h0,       1, 0);
        step(2, 1, 1, 4'h3, 0, 4'hF, 4'h2, 64'h1234,     64'h0,        0, 4'h2, 4'h5, 64'h1234,     64'h5,       1, 0);
        step(3, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,        64'h0,        0, 4'h2, 4'hF, 64'h1234,     64'h0,       1, 1);
        step(4, 1, 1, 4'h2, 0, 4'hF, 4'h5, 64'h99,       64'h0,        0, 4'h5, 4'hF, 64'h5,        64'h0,       1, 1);
        step(5, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,        64'h0,        0, 4'h5, 4'hF, 64'h5,        64'h0,       1, 2);
        step(6, 1, 1, 4'hB, 0, 4'h4, 4'hF, 64'h100,      64'hBEEF,     0, 4'h4, 4'h4, 64'hBEEF,     64'hBEEF,    1, 2);
        step(7, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,        64'h0,        0, 4'h4, 4'hF, 64'hBEEF,     64'h0,       1, 3);
        step(8, 1, 1, 4'h2, 1, 4'hF, 4'h6, 64'h77,       64'h0,        0, 4'h6, 4'hF, 64'h77,       64'h0,       1, 3);
        step(9, 1, 1, 4'h6, 0, 4'hF, 4'h6, 64'h55,       64'h0,        0, 4'h6, 4'h7, 64'h55,       64'h7,       1, 4);
        step(10, 1, 1, 4'h5, 0, 4'h7, 4'hF, 64'hAAAA,    64'hCAFE,     0, 4'h7, 4'h6, 64'hCAFE,     64'h55,      1, 5);
        step(11, 1, 1, 4'h9, 0, 4'hF, 4'hF, 64'h200,     64'h9999,     0, 4'h4, 4'h7, 64'h200,      64'hCAFE,    1, 6);
        // halt retires; following irmovq must be ignored
        step(12, 1, 1, 4'h0, 0, 4'hF, 4'hF, 64'h0,       64'h0,        0, 4'h4, 4'hF, 64'h200,      64'h0,       1, 7);
        step(13, 1, 1, 4'h3, 0, 4'hF, 4'h1, 64'hDEAD,    64'h0,        0, 4'h1, 4'hF, 64'h1,        64'h0,       2, 8);
        step(14, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,       64'h0,        0, 4'h1, 4'h4, 64'h1,        64'h200,     2, 8);
        // async reset sampled before the next clock edge; write in flight is discarded
        step(15, 0, 1, 4'h3, 0, 4'hF, 4'h2, 64'hFF,      64'h0,        0, 4'h2, 4'h4, 64'h2,        64'h4,       1, 0);
        step(16, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,       64'h0,        0, 4'h2, 4'h6, 64'h2,        64'h6,       1, 0);
        // ADR beats INS, no write
        step(17, 1, 1, 4'hC, 0, 4'hF, 4'h3, 64'h4444,    64'h0,        1, 4'h3, 4'hF, 64'h3,        64'h0,       1, 0);
        step(18, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,       64'h0,        0, 4'h3, 4'hF, 64'h3,        64'h0,       3, 0);
        step(19, 0, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,       64'h0,        0, 4'h3, 4'hF, 64'h3,        64'h0,       1, 0);
        step(20, 1, 1, 4'hD, 0, 4'hF, 4'h3, 64'h4444,    64'h0,        0, 4'h3, 4'hF, 64'h3,        64'h0,       1, 0);
        step(21, 1, 0, 4'h1, 0, 4'hF, 4'hF, 64'h0,       64'h0,        0, 4'h3, 4'hF, 64'h3,        64'h0,       4, 0);
        done = 1'b1;
    end

endmodule
